// File: rtl/div_nr_multi.sv
// Iterative non-restoring divider covering DIV/DIVU/REM/REMU, with
// BITS_PER_CYCLE unrolled steps, optional |a|<|b| early-out and abort.
module div_nr_multi #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_OUT      = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] result
);
  localparam int L     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(L + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LOOP, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]              op_q, op_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d, bmag_q, bmag_d;
  logic [WIDTH-1:0]        quo_q, quo_d, q_q, q_d, r_q, r_d;
  logic signed [WIDTH:0]   rem_q, rem_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // One step: shift {rem,quo} left, add or subtract the divisor depending on
  // the sign of the remainder before the shift, append the new quotient bit.
  function automatic logic [2*WIDTH:0] nr_step(input logic signed [WIDTH:0] rem,
                                               input logic [WIDTH-1:0] quo,
                                               input logic [WIDTH-1:0] d);
    logic signed [WIDTH:0] sh, nx;
    sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    nx = rem[WIDTH] ? sh + $signed({1'b0, d}) : sh - $signed({1'b0, d});
    return {nx, quo[WIDTH-2:0], ~nx[WIDTH]};
  endfunction

  logic                  sgn, a_neg, b_neg, dz, ovf, eo;
  logic [WIDTH-1:0]      amag, bmag, q_fix, r_fix, loop_quo;
  logic signed [WIDTH:0] rem_fix, loop_rem;

  assign sgn   = ~op_q[0];
  assign a_neg = sgn & a_q[WIDTH-1];
  assign b_neg = sgn & b_q[WIDTH-1];
  assign amag  = a_neg ? neg(a_q) : a_q;
  assign bmag  = b_neg ? neg(b_q) : b_q;
  assign dz    = (b_q == '0);
  assign ovf   = sgn && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  assign eo    = EARLY_OUT && (amag < bmag);

  always_comb begin
    loop_rem = rem_q;
    loop_quo = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      {loop_rem, loop_quo} = nr_step(loop_rem, loop_quo, bmag_q);
    end
  end

  assign rem_fix = rem_q[WIDTH] ? rem_q + $signed({1'b0, bmag_q}) : rem_q;
  assign q_fix   = (sa_q ^ sb_q) ? neg(quo_q) : quo_q;
  assign r_fix   = sa_q ? neg(rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];

  assign in_ready  = (state_q == S_IDLE) && !abort;
  assign out_valid = (state_q == S_DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign result    = op_q[1] ? r_q : q_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bmag_d  = bmag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_PRE;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      S_PRE: begin
        sa_d   = a_neg;
        sb_d   = b_neg;
        bmag_d = bmag;
        rem_d  = '0;
        quo_d  = amag;
        cnt_d  = '0;
        state_d = S_DONE;
        if (dz) begin
          q_d = '1;
          r_d = a_q;
        end else if (ovf) begin
          q_d = a_q;
          r_d = '0;
        end else if (eo) begin
          q_d = '0;
          r_d = a_q;
        end else begin
          state_d = S_LOOP;
        end
      end
      S_LOOP: begin
        rem_d = loop_rem;
        quo_d = loop_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(L - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        rem_d   = rem_fix;
        q_d     = q_fix;
        r_d     = r_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bmag_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bmag_q  <= bmag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_div_nr_multi.sv
// Bench for div_nr_multi: five configurations driven in lock-step and
// checked every cycle against an arithmetic reference model.
module tb_div_nr_multi;
  localparam int NI = 5;
  localparam int BPC_T [NI] = '{1, 2, 4, 8, 1};
  localparam bit EO_T  [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic        clk, resetn, in_valid, abort, out_ready;
  logic [1:0]  op_s;
  logic [31:0] a_s, b_s;
  logic [NI-1:0] in_ready_w, out_valid_w;
  logic [31:0] q_w [NI];
  logic [31:0] r_w [NI];
  logic [31:0] res_w [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    div_nr_multi #(.WIDTH(32), .BITS_PER_CYCLE(BPC_T[k]), .EARLY_OUT(EO_T[k])) u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_w[k]),
      .op(op_s), .a(a_s), .b(b_s), .abort(abort), .out_valid(out_valid_w[k]),
      .out_ready(out_ready), .q(q_w[k]), .r(r_w[k]), .result(res_w[k]));
  end

  int n_cmp = 0, n_fail = 0, cycle = 0, acc_cyc = 0;
  logic [31:0] exp_q [NI];
  logic [31:0] exp_r [NI];
  logic [31:0] exp_res [NI];
  int          exp_lat [NI];
  logic [NI-1:0] busy, seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  task automatic ref_div(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] rq, output logic [31:0] rr);
    longint sa, sb;
    if (bv == 32'd0) begin
      rq = 32'hFFFF_FFFF;
      rr = av;
    end else if (!o[0]) begin
      if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
        rq = av;
        rr = 32'd0;
      end else begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        rq = 32'(sa / sb);
        rr = 32'(sa % sb);
      end
    end else begin
      rq = av / bv;
      rr = av % bv;
    end
  endtask

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? 32'(-x) : x;
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] av,
                                    input logic [31:0] bv, input bit eo);
    bit s = !o[0];
    return (bv == 0) || (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) ||
           (eo && (mag(s, av) < mag(s, bv)));
  endfunction

  task automatic accept(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] eq, er;
    @(negedge clk);
    in_valid = 1'b1; op_s = o; a_s = av; b_s = bv;
    @(posedge clk); #1;
    ref_div(o, av, bv, eq, er);
    for (int k = 0; k < NI; k++) begin
      exp_q[k]   = eq;
      exp_r[k]   = er;
      exp_res[k] = o[1] ? er : eq;
      exp_lat[k] = is_special(o, av, bv, EO_T[k]) ? 1 : 32 / BPC_T[k] + 2;
    end
    acc_cyc = cycle;
    busy = '1;
    op_s = ~o; a_s = $urandom; b_s = $urandom;
  endtask

  task automatic do_req(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    int n;
    accept(o, av, bv);
    n = 0;
    while (out_valid_w != '1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    busy = '0;
    repeat (2) @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!resetn) begin
        chk($sformatf("u%0d rst out_valid", k), {31'b0, out_valid_w[k]}, 32'd0);
        chk($sformatf("u%0d rst q", k), q_w[k], 32'd0);
        chk($sformatf("u%0d rst r", k), r_w[k], 32'd0);
        chk($sformatf("u%0d rst result", k), res_w[k], 32'd0);
        chk($sformatf("u%0d rst in_ready", k), {31'b0, in_ready_w[k]}, 32'd1);
        seen[k] = 1'b0;
      end else if (!busy[k]) begin
        seen[k] = 1'b0;
        chk($sformatf("u%0d idle out_valid", k), {31'b0, out_valid_w[k]}, 32'd0);
        chk($sformatf("u%0d idle in_ready", k), {31'b0, in_ready_w[k]}, {31'b0, ~abort});
      end else begin
        chk($sformatf("u%0d busy in_ready", k), {31'b0, in_ready_w[k]}, 32'd0);
        if (out_valid_w[k]) begin
          if (!seen[k]) begin
            chk($sformatf("u%0d latency", k), 32'(cycle - acc_cyc), 32'(exp_lat[k]));
            seen[k] = 1'b1;
          end
          chk($sformatf("u%0d q", k), q_w[k], exp_q[k]);
          chk($sformatf("u%0d r", k), r_w[k], exp_r[k]);
          chk($sformatf("u%0d result", k), res_w[k], exp_res[k]);
        end else if (seen[k]) begin
          chk($sformatf("u%0d out_valid held", k), {31'b0, out_valid_w[k]}, 32'd1);
        end else if (cycle - acc_cyc > exp_lat[k]) begin
          chk($sformatf("u%0d latency", k), 32'(cycle - acc_cyc), 32'(exp_lat[k]));
          seen[k] = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] mq, mr, ra, rb;
    resetn = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    op_s = 2'b00; a_s = 32'd0; b_s = 32'd0; busy = '0; seen = '0;

    ref_div(2'b00, 32'd100, 32'd7, mq, mr);
    chk("model div q", mq, 32'd14);
    chk("model div r", mr, 32'd2);
    ref_div(2'b00, 32'hFFFF_FFF9, 32'd2, mq, mr);
    chk("model sdiv q", mq, 32'hFFFF_FFFD);
    chk("model sdiv r", mr, 32'hFFFF_FFFF);
    ref_div(2'b10, 32'd7, 32'hFFFF_FFFE, mq, mr);
    chk("model srem q", mq, 32'hFFFF_FFFD);
    chk("model srem r", mr, 32'd1);
    ref_div(2'b01, 32'd5, 32'd0, mq, mr);
    chk("model div0 q", mq, 32'hFFFF_FFFF);
    chk("model div0 r", mr, 32'd5);
    ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, mq, mr);
    chk("model ovf q", mq, 32'h8000_0000);
    chk("model ovf r", mr, 32'd0);
    ref_div(2'b01, 32'hFFFF_FFFF, 32'h10, mq, mr);
    chk("model divu q", mq, 32'h0FFF_FFFF);
    chk("model divu r", mr, 32'hF);

    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    do_req(2'b00, 32'd100, 32'd7);
    do_req(2'b11, 32'd100, 32'd7);
    do_req(2'b00, 32'hFFFF_FFF9, 32'd2);
    do_req(2'b10, 32'd7, 32'hFFFF_FFFE);
    do_req(2'b01, 32'd5, 32'd0);
    do_req(2'b10, 32'hFFFF_FFFB, 32'd0);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_req(2'b00, 32'h8000_0000, 32'd1);
    do_req(2'b01, 32'd3, 32'd10);
    do_req(2'b01, 32'hFFFF_FFFF, 32'h10);
    do_req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_req(2'b11, 32'd0, 32'd5);

    // Abort mid-LOOP, then abort while idle must block acceptance.
    accept(2'b00, 32'd1000, 32'd7);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    busy = '0;
    repeat (3) @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; op_s = 2'b00; a_s = 32'd50; b_s = 32'd5;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    do_req(2'b00, 32'd9, 32'd3);

    // Reset pulse while the dividers are iterating.
    accept(2'b01, 32'd12345, 32'd17);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    busy = '0;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom) : {22'd0, 10'($urandom)};
      if (i % 4 == 1) rb = 32'(-rb);
      do_req(2'(i % 4), ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
